vga_player_overlay: RTL

Consumes the two 128-bit per-player VGA descriptors (p1VGA, p2VGA) produced by the MMIO/coprocessor block. Each frame it latches them into shadow registers at vertical-blank start. For every incoming pixel coordinate it decides which layer owns the pixel (background, player 1, player 2) and which colour index to show. The result feeds the downstream VGA colour mux through a fixed 2-cycle pipeline.

---
 rtl/vga_player_overlay.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vga_player_overlay.sv
// vga_player_overlay
// Decides, for every incoming pixel coordinate, which layer owns the pixel
// (background, player 1 or player 2) and which colour index it shows. The
// two 128-bit player descriptors are latched into shadow registers at the
// start of vertical blank, so a frame is always drawn from one consistent
// snapshot.
//
// Descriptor layout (per player):
//   [127:112] x   [111:96] y   [95:80] w   [79:64] h
//   [8] hit flag  [9] facing-left  [7:0] colour  (all other bits ignored)
//
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   p1VGA, p2VGA       live player descriptors
//   vsync_start        one-cycle pulse: load shadows, advance frame counters
//   pix_valid/x/y      pixel coordinate in
//   out_valid          pix_valid delayed exactly 2 cycles
//   out_layer          0 = background, 1 = P1, 2 = P2
//   out_color          colour index, 0 for background or when not valid
//   frame_count        vsync_start pulses since reset (wraps)
//
// Handshake: valid-only streaming, no ready/back-pressure. A coordinate
// presented with pix_valid = 1 is accepted on that clock edge, and its result
// appears with out_valid = 1 exactly two edges later; outputs are 0 whenever
// out_valid = 0.
//
// Optional build macro OVERLAY_OUTLINE_EN: draws an 8'hFF outline on the top
// and bottom rows and on the facing-side column (left if facing-left, else
// right) of each player box. Undefined: plain descriptor colour everywhere.
module vga_player_overlay #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BLINK_PERIOD = 8,
  parameter int P1_ON_TOP    = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] p1VGA,
  input  logic [127:0] p2VGA,
  input  logic         vsync_start,
  input  logic         pix_valid,
  input  logic [9:0]   pix_x,
  input  logic [9:0]   pix_y,
  output logic         out_valid,
  output logic [1:0]   out_layer,
  output logic [7:0]   out_color,
  output logic [15:0]  frame_count
);

  localparam int BW = $clog2(BLINK_PERIOD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_PERIOD / 2);
  localparam logic [16:0]   SW17       = 17'(SCREEN_W);
  localparam logic [16:0]   SH17       = 17'(SCREEN_H);

  // Live descriptors as an array so both players share one code path.
  logic [127:0] live [2];
  assign live[0] = p1VGA;
  assign live[1] = p2VGA;

  logic unused_bits;
`ifdef OVERLAY_OUTLINE_EN
  assign unused_bits = ^{p1VGA[63:10], p2VGA[63:10]};
`else
  assign unused_bits = ^{p1VGA[63:9], p2VGA[63:9]};
`endif

  // Shadow copies: only the fields the overlay uses.
  logic [15:0] sh_x   [2];
  logic [15:0] sh_y   [2];
  logic [15:0] sh_w   [2];
  logic [15:0] sh_h   [2];
  logic [7:0]  sh_col [2];
  logic        sh_hit [2];
`ifdef OVERLAY_OUTLINE_EN
  logic        sh_face [2];
`endif
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        sh_x[p]   <= '0;
        sh_y[p]   <= '0;
        sh_w[p]   <= '0;
        sh_h[p]   <= '0;
        sh_col[p] <= '0;
        sh_hit[p] <= 1'b0;
`ifdef OVERLAY_OUTLINE_EN
        sh_face[p] <= 1'b0;
`endif
      end
      blink_cnt   <= '0;
      frame_count <= '0;
    end else if (vsync_start) begin
      for (int p = 0; p < 2; p++) begin
        sh_x[p]   <= live[p][127:112];
        sh_y[p]   <= live[p][111:96];
        sh_w[p]   <= live[p][95:80];
        sh_h[p]   <= live[p][79:64];
        sh_col[p] <= live[p][7:0];
        sh_hit[p] <= live[p][8];
`ifdef OVERLAY_OUTLINE_EN
        sh_face[p] <= live[p][9];
`endif
      end
      blink_cnt   <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
      frame_count <= frame_count + 16'd1;
    end
  end

  // Stage 1 combinational hit test. All box arithmetic is 17 bits wide so
  // x+w / y+h never wrap; w = 0 or h = 0 yields an empty interval.
  logic [16:0] px, py;
  logic        on_screen;
  logic        fade;
  logic [16:0] x_end [2];
  logic [16:0] y_end [2];
  logic [1:0]  in_box;
  logic [1:0]  own;
  logic [7:0]  col [2];
`ifdef OVERLAY_OUTLINE_EN
  logic [1:0]  edge_lr;
  logic [1:0]  edge_tb;
`endif

  always_comb begin
    px        = {7'd0, pix_x};
    py        = {7'd0, pix_y};
    on_screen = (px < SW17) && (py < SH17);
    fade      = (blink_cnt >= BLINK_HALF);
    in_box    = '0;
    own       = '0;
`ifdef OVERLAY_OUTLINE_EN
    edge_lr   = '0;
    edge_tb   = '0;
`endif
    for (int p = 0; p < 2; p++) begin
      x_end[p]  = {1'b0, sh_x[p]} + {1'b0, sh_w[p]};
      y_end[p]  = {1'b0, sh_y[p]} + {1'b0, sh_h[p]};
      in_box[p] = on_screen &&
                  (px >= {1'b0, sh_x[p]}) && (px < x_end[p]) &&
                  (py >= {1'b0, sh_y[p]}) && (py < y_end[p]);
      // A hit player blinks: hidden during the second half of each cycle.
      own[p]    = in_box[p] && !(sh_hit[p] && fade);
      col[p]    = sh_col[p];
`ifdef OVERLAY_OUTLINE_EN
      edge_lr[p] = sh_face[p] ? (px == {1'b0, sh_x[p]})
                              : (px == x_end[p] - 17'd1);
      edge_tb[p] = (py == {1'b0, sh_y[p]}) || (py == y_end[p] - 17'd1);
      if (in_box[p] && (edge_lr[p] || edge_tb[p]))
        col[p] = 8'hFF;
`endif
    end
  end

  // Stage 1 registers. Ownership is gated by pix_valid so invalid slots carry
  // no ownership into stage 2 and the outputs fall to 0 naturally.
  logic       s1_valid;
  logic [1:0] s1_own;
  logic [7:0] s1_col [2];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_own    <= '0;
      s1_col[0] <= '0;
      s1_col[1] <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_own    <= pix_valid ? own : 2'b00;
      s1_col[0] <= col[0];
      s1_col[1] <= col[1];
    end
  end

  // Stage 2: priority select.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_layer <= 2'd0;
      out_color <= 8'd0;
    end else begin
      out_valid <= s1_valid;
      if (s1_own[0] && ((P1_ON_TOP != 0) || !s1_own[1])) begin
        out_layer <= 2'd1;
        out_color <= s1_col[0];
      end else if (s1_own[1]) begin
        out_layer <= 2'd2;
        out_color <= s1_col[1];
      end else begin
        out_layer <= 2'd0;
        out_color <= 8'd0;
      end
    end
  end

endmodule
